// File: rtl/alu_pkg.sv
// Shared ALUOp encodings and FSM state type for the multi-cycle ALU.
package alu_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_XOR = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_SRA = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU slice: ADD/XOR/AND. For SRA it passes operand a through,
// which is exactly the answer for a zero shift amount.
module alu_comb
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  // Operation select; carry out of ADD is dropped by the WIDTH-bit result.
  always_comb begin
    y = a;
    case (alu_op)
      ALU_ADD: y = a + b;
      ALU_XOR: y = a ^ b;
      ALU_AND: y = a & b;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/alu_exec_mc.sv
// Multi-cycle ALU executor: single-cycle ops finish on the accept edge,
// SRA shifts one bit per cycle through a local shift register.
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// SHIFT | SRA in progress, one bit per cycle, cnt_q bits left
// DONE  | result valid, held until out_ready is sampled high
module alu_exec_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] comb_y;
  logic [SHW-1:0]   shamt;

  assign shamt = b[SHW-1:0];

  alu_comb #(.WIDTH(WIDTH)) u_alu_comb (
    .alu_op (alu_op),
    .a      (a),
    .b      (b),
    .y      (comb_y)
  );

  // Next-state and datapath decisions; everything holds unless a branch loads it.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (alu_op == ALU_SRA && shamt != '0) begin
            sh_d    = a;
            cnt_d   = shamt;
            state_d = SHIFT;
          end else begin
            result_d = comb_y;
            zero_d   = (comb_y == '0);
            state_d  = DONE;
          end
        end
      end
      SHIFT: begin
        sh_d  = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == SHW'(1)) begin
          result_d = sh_d;
          zero_d   = (sh_d == '0);
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
      sh_q     <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      sh_q     <= sh_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_exec_mc.sv
// Self-checking bench for alu_exec_mc: directed spec cases plus randomized
// traffic against a plain-arithmetic reference model.
module tb_alu_exec_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  alu_op;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  alu_exec_mc #(.WIDTH(32), .SHW(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  // Reference: 00 ADD, 01 XOR, 10 AND, 11 arithmetic shift right by y[4:0].
  function automatic logic [31:0] ref_result(logic [1:0] op, logic [31:0] x, logic [31:0] y);
    logic [4:0] n;
    n = y[4:0];
    case (op)
      2'b00:   return x + y;
      2'b01:   return x ^ y;
      2'b10:   return x & y;
      default: return 32'($signed(x) >>> n);
    endcase
  endfunction

  // Edges from (and including) the accept edge until out_valid is seen.
  function automatic int ref_lat(logic [1:0] op, logic [31:0] y);
    logic [4:0] n;
    n = y[4:0];
    if (op == 2'b11 && n != 5'd0) return int'(n) + 1;
    return 1;
  endfunction

  // Present one request for exactly one edge; afterwards scramble the inputs.
  task automatic issue(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_in_ready: got %b want 1", in_ready);
    end
    alu_op   = op;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    alu_op   = 2'($urandom);
    a        = $urandom;
    b        = $urandom;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL wait_valid_timeout: out_valid %b after %0d cycles, want 1", out_valid, lat);
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; alu_op = 2'b00; a = 32'd5; b = 32'd6; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero: got %b want 1", zero); end
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_idle: in_ready %b want 1", in_ready); end
  endtask

  task automatic test_single_cycle();
    vec_t tbl[3];
    int lat;
    tbl[0] = '{2'b00, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1};
    tbl[1] = '{2'b01, 32'hA5A5A5A5, 32'hFFFF0000, 32'h5A5AA5A5, 1};
    tbl[2] = '{2'b10, 32'hA5A5A5A5, 32'hFFFF0000, 32'hA5A50000, 1};
    for (int i = 0; i < 3; i++) begin
      issue(tbl[i].op, tbl[i].x, tbl[i].y);
      wait_valid(lat);
      checks++; if (lat != tbl[i].lat) begin errors++; $display("FAIL single_lat[%0d]: got %0d want %0d", i, lat, tbl[i].lat); end
      checks++; if (result !== tbl[i].exp) begin errors++; $display("FAIL single_result[%0d]: got %h want %h", i, result, tbl[i].exp); end
      checks++; if (zero !== (tbl[i].exp == 32'h0)) begin errors++; $display("FAIL single_zero[%0d]: got %b want %b", i, zero, tbl[i].exp == 32'h0); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL single_busy[%0d]: in_ready %b want 0", i, in_ready); end
      consume();
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL single_release[%0d]: in_ready %b out_valid %b want 1 0", i, in_ready, out_valid); end
    end
  endtask

  task automatic test_sra();
    vec_t tbl[4];
    int lat;
    tbl[0] = '{2'b11, 32'h80000000, 32'd31,       32'hFFFFFFFF, 32};
    tbl[1] = '{2'b11, 32'h7FFFFFFF, 32'h00000024, 32'h07FFFFFF, 5};
    tbl[2] = '{2'b11, 32'h12345678, 32'h00000000, 32'h12345678, 1};
    tbl[3] = '{2'b11, 32'h7FFFFFFF, 32'd31,       32'h00000000, 32};
    for (int i = 0; i < 4; i++) begin
      issue(tbl[i].op, tbl[i].x, tbl[i].y);
      wait_valid(lat);
      checks++; if (lat != tbl[i].lat) begin errors++; $display("FAIL sra_lat[%0d]: got %0d want %0d", i, lat, tbl[i].lat); end
      checks++; if (result !== tbl[i].exp) begin errors++; $display("FAIL sra_result[%0d]: got %h want %h", i, result, tbl[i].exp); end
      checks++; if (zero !== (tbl[i].exp == 32'h0)) begin errors++; $display("FAIL sra_zero[%0d]: got %b want %b", i, zero, tbl[i].exp == 32'h0); end
      consume();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    issue(2'b00, 32'd3, 32'd4);
    wait_valid(lat);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      alu_op   = 2'($urandom);
      a        = $urandom;
      b        = $urandom;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || result !== 32'd7 || zero !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: valid %b result %h zero %b in_ready %b want 1 00000007 0 0",
                 i, out_valid, result, zero, in_ready);
      end
    end
    in_valid = 1'b0;
    consume();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL backpressure_consume: valid %b in_ready %b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_back_to_back();
    int lat;
    issue(2'b01, 32'h0F0F0F0F, 32'h00FF00FF);
    wait_valid(lat);
    checks++; if (result !== 32'h0FF00FF0) begin errors++; $display("FAIL b2b_first: got %h want 0ff00ff0", result); end
    consume();
    issue(2'b00, 32'd100, 32'd23);
    wait_valid(lat);
    checks++; if (result !== 32'd123 || lat != 1) begin errors++; $display("FAIL b2b_second: got %h lat %0d want 0000007b lat 1", result, lat); end
    consume();
  endtask

  task automatic test_reset_abort();
    int lat;
    bit saw;
    issue(2'b11, 32'h80001234, 32'd20);
    repeat (7) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_midshift_valid: got %b want 0", out_valid); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'h0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL abort_shift_state: in_ready %b valid %b result %h zero %b want 1 0 0 1", in_ready, out_valid, result, zero);
    end
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) saw = 1'b1;
    end
    checks++; if (saw) begin errors++; $display("FAIL abort_no_result: out_valid seen after abort, want never"); end
    issue(2'b00, 32'd1, 32'd2);
    wait_valid(lat);
    out_ready = 1'b1;
    rst_n     = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || result !== 32'h0 || zero !== 1'b1) begin
      errors++;
      $display("FAIL abort_done_state: valid %b result %h zero %b want 0 0 1", out_valid, result, zero);
    end
    rst_n = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int lat, stall;
    logic [1:0]  op;
    logic [31:0] x, y, exp;
    bit early;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      x  = $urandom;
      y  = (i % 8 == 0) ? 32'h0 : $urandom;
      exp   = ref_result(op, x, y);
      early = 1'($urandom_range(0, 1));
      out_ready = early;
      issue(op, x, y);
      wait_valid(lat);
      checks++; if (lat != ref_lat(op, y)) begin errors++; $display("FAIL rand_lat[%0d]: got %0d want %0d", i, lat, ref_lat(op, y)); end
      checks++; if (result !== exp) begin errors++; $display("FAIL rand_result[%0d]: op %0d got %h want %h", i, op, result, exp); end
      checks++; if (zero !== (exp == 32'h0)) begin errors++; $display("FAIL rand_zero[%0d]: got %b want %b", i, zero, exp == 32'h0); end
      if (!early) begin
        stall = $urandom_range(0, 3);
        for (int s = 0; s < stall; s++) begin
          @(posedge clk); #1;
          checks++; if (out_valid !== 1'b1 || result !== exp) begin errors++; $display("FAIL rand_hold[%0d]: valid %b result %h want 1 %h", i, out_valid, result, exp); end
        end
      end
      consume();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rand_release[%0d]: in_ready %b want 1", i, in_ready); end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; alu_op = 2'b00; a = '0; b = '0; out_ready = 1'b0;
    test_reset();
    test_single_cycle();
    test_sra();
    test_backpressure();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_mc.md
ALU_EXEC_MC -- requirements
Module: alu_exec_mc

Interface
REQ-001 Parameter: WIDTH, default 32, datapath width in bits.
REQ-002 Parameter: SHW, default 5, shift-amount width; SHALL equal log2(WIDTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 in_valid  input  1  operation request present.
REQ-006 in_ready  output  1  block able to accept a request.
REQ-007 alu_op  input  2  ALUOp code: 00 ADD, 01 XOR, 10 AND, 11 SRA.
REQ-008 a  input  WIDTH  operand A; shifted operand for SRA.
REQ-009 b  input  WIDTH  operand B; b[SHW-1:0] is the shift amount for SRA, upper bits ignored.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  WIDTH  registered operation result.
REQ-013 zero  output  1  registered; high when result == 0.

Function
REQ-014 States SHALL be IDLE, SHIFT, DONE; in_ready SHALL be high only in IDLE.
REQ-015 Accept SHALL occur on a rising edge where in_valid && in_ready; alu_op, a and b SHALL be captured on that edge only.
REQ-016 ADD SHALL compute (a + b) mod 2^WIDTH; carry and overflow discarded.
REQ-017 XOR SHALL compute a ^ b; AND SHALL compute a & b.
REQ-018 ADD/XOR/AND: the accept edge SHALL load result and move IDLE->DONE; out_valid high the next cycle (latency 1).
REQ-019 SRA with shamt == 0: the accept edge SHALL load result = a and move to DONE (latency 1).
REQ-020 SRA with shamt N > 0: the accept edge SHALL load the shift register with a and the counter with N, then move to SHIFT.
REQ-021 In SHIFT each cycle SHALL arithmetic-shift right by one bit (MSB replicated) and decrement the counter; when the counter is 1, move to DONE; out_valid high N+1 cycles after the accept edge.
REQ-022 SRA of a negative operand by WIDTH-1 SHALL yield all ones; of a non-negative operand, zero.
REQ-023 In DONE, out_valid SHALL be high and result/zero SHALL be held stable until out_ready is sampled high.
REQ-024 DONE with out_ready high SHALL move to IDLE; the next accept is possible no earlier than the following edge (maximum throughput one operation per two cycles).
REQ-025 in_valid asserted outside IDLE SHALL be ignored and SHALL NOT alter any state.
REQ-026 out_ready asserted outside DONE SHALL have no effect.
REQ-027 zero SHALL be updated on the same edge as result.

Reset
REQ-028 rst_n low at a rising edge SHALL force state IDLE, out_valid 0, result 0, zero 1, counter 0, in_ready 1 the following cycle.
REQ-029 Reset during SHIFT or DONE SHALL abort the operation; no result SHALL be presented afterwards.
REQ-030 Reset SHALL take priority over accept and over out_ready in the same cycle.

Structure
REQ-031 A shared package alu_pkg SHALL hold the ALUOp encodings (ALU_ADD, ALU_XOR, ALU_AND, ALU_SRA) and the state enum typedef; the control-unit decoder SHALL use the same constants.
REQ-032 One sub-module alu_comb SHALL compute the single-cycle ADD/XOR/AND result combinationally; the FSM, shift register and counter SHALL reside in alu_exec_mc.

Verification
REQ-033 Reset with in_valid high -> in_ready 1, out_valid 0, result 0, zero 1; no accept until rst_n high.
REQ-034 ADD a=0xFFFFFFFF, b=0x00000001, out_ready high -> out_valid one cycle after accept, result 0x00000000, zero 1; in_ready returns high the cycle after.
REQ-035 XOR a=0xA5A5A5A5, b=0xFFFF0000 -> 0x5A5AA5A5; AND with same operands -> 0xA5A50000; zero 0.
REQ-036 SRA a=0x80000000, b=31 -> out_valid 32 cycles after accept, result 0xFFFFFFFF; SRA a=0x7FFFFFFF, b=0x00000024 (shamt 4) -> 0x07FFFFFF after 5 cycles; SRA b=0 -> result a after 1 cycle.
REQ-037 Backpressure: out_ready low for 5 cycles in DONE, in_valid toggled with new operands -> result held, in_ready 0, no capture; result consumed on the first out_ready high.
REQ-038 Reset asserted mid-SHIFT (SRA shamt 20, reset after 7 cycles) -> IDLE next cycle, out_valid never asserted for the aborted operation.
